// File: rtl/decode_sel_arbiter.sv
// decode_sel_arbiter: two-requester arbiter/sequencer for the shared select/decode datapath.
// Ports:
//   Clock, Reset_n        rising-edge clock, synchronous active-low reset
//   A_req/A_data/A_gnt    requester A: request, 2-bit operand, completion pulse
//   B_req/B_data/B_gnt    requester B: request, 2-bit operand, completion pulse
//   Sel_out               mux select (0 = A operand, 1 = B operand)
//   Mux_data_out          registered copy of the granted operand
//   Settle_done           capture strobe, coincident with the grant pulse
//   Busy                  high outside IDLE
//   Last_grant            requester served last (0 = A, 1 = B)
module decode_sel_arbiter #(
    parameter int SETTLE_CYCLES = 3,
    parameter bit RR_EN         = 1'b1,
    parameter int CNT_W         = 4
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       A_req,
    input  logic [1:0] A_data,
    output logic       A_gnt,
    input  logic       B_req,
    input  logic [1:0] B_data,
    output logic       B_gnt,
    output logic       Sel_out,
    output logic [1:0] Mux_data_out,
    output logic       Settle_done,
    output logic       Busy,
    output logic       Last_grant
);
    typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(SETTLE_CYCLES - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic pend, pend_sel, win_sel, sample, done;
    // IDLE is two-phase: the request is sampled (winner chosen) at one edge and the
    // winner's operand is latched at the following edge.
    always_comb begin
        win_sel = (A_req && B_req) ? (RR_EN ? ~Last_grant : 1'b0) : B_req;
        sample  = (state == IDLE) && !pend && (A_req || B_req);
        done    = (state == SETTLE) && (cnt == '0);
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = pend ? SETTLE : IDLE;
            SETTLE:  state_nx = done ? GRANT : SETTLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pend         <= 1'b0;
            pend_sel     <= 1'b0;
            Sel_out      <= 1'b0;
            Mux_data_out <= 2'b00;
            A_gnt        <= 1'b0;
            B_gnt        <= 1'b0;
            Settle_done  <= 1'b0;
            Last_grant   <= 1'b1;
        end else begin
            state <= state_nx;
            pend  <= sample;
            if (sample)
                pend_sel <= win_sel;
            if (state == IDLE && pend) begin
                Sel_out      <= pend_sel;
                Mux_data_out <= pend_sel ? B_data : A_data;
                cnt          <= LOAD;
            end else if (state == SETTLE && !done)
                cnt <= cnt - 1'b1;
            // Sel_out is frozen for the whole transaction, so it names the winner.
            A_gnt       <= done && !Sel_out;
            B_gnt       <= done && Sel_out;
            Settle_done <= done;
            if (done)
                Last_grant <= Sel_out;
        end
    end
    assign Busy = (state != IDLE);
endmodule

// File: tb/tb_decode_sel_arbiter.sv
// tb_decode_sel_arbiter: directed bench for decode_sel_arbiter (round-robin and fixed-priority instances).
module tb_decode_sel_arbiter;
    localparam int S = 3;
    logic Clock, Reset_n, A_req, B_req;
    logic [1:0] A_data, B_data;
    logic [1:0] a_gnt, b_gnt, sel, done, busy, last;
    logic [1:0] mux_o [2];
    int checks = 0;
    int errors = 0;
    bit mvalid = 0;
    typedef struct {
        bit act; bit pend; bit pwin; int t;
        bit sel; logic [1:0] data; bit last; bit ga; bit gb;
    } m_t;
    m_t m [2];

    decode_sel_arbiter #(.SETTLE_CYCLES(S), .RR_EN(1'b1), .CNT_W(4)) u_rr (
        .Clock(Clock), .Reset_n(Reset_n),
        .A_req(A_req), .A_data(A_data), .A_gnt(a_gnt[0]),
        .B_req(B_req), .B_data(B_data), .B_gnt(b_gnt[0]),
        .Sel_out(sel[0]), .Mux_data_out(mux_o[0]), .Settle_done(done[0]),
        .Busy(busy[0]), .Last_grant(last[0]));

    decode_sel_arbiter #(.SETTLE_CYCLES(S), .RR_EN(1'b0), .CNT_W(4)) u_fp (
        .Clock(Clock), .Reset_n(Reset_n),
        .A_req(A_req), .A_data(A_data), .A_gnt(a_gnt[1]),
        .B_req(B_req), .B_data(B_data), .B_gnt(b_gnt[1]),
        .Sel_out(sel[1]), .Mux_data_out(mux_o[1]), .Settle_done(done[1]),
        .Busy(busy[1]), .Last_grant(last[1]));

    initial Clock = 0;
    always #5 Clock = ~Clock;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Transaction-timeline model: t counts edges since the operand was latched;
    // the grant is visible when t == S and the transaction ends one edge later.
    always @(posedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!Reset_n) begin
                m[k].act = 0; m[k].pend = 0; m[k].pwin = 0; m[k].t = 0;
                m[k].sel = 0; m[k].data = 2'b00; m[k].last = 1; m[k].ga = 0; m[k].gb = 0;
                mvalid = 1;
            end else begin
                m[k].ga = 0;
                m[k].gb = 0;
                if (m[k].act) begin
                    m[k].t++;
                    if (m[k].t == S) begin
                        m[k].ga = !m[k].sel;
                        m[k].gb = m[k].sel;
                        m[k].last = m[k].sel;
                    end
                    if (m[k].t == S + 1) m[k].act = 0;
                end else if (m[k].pend) begin
                    m[k].act = 1;
                    m[k].t = 0;
                    m[k].pend = 0;
                    m[k].sel = m[k].pwin;
                    m[k].data = m[k].pwin ? B_data : A_data;
                end else if (A_req || B_req) begin
                    m[k].pend = 1;
                    m[k].pwin = (A_req && B_req) ? (k == 0 ? !m[k].last : 1'b0) : B_req;
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d_a_gnt", k), a_gnt[k], m[k].ga);
                chk($sformatf("m%0d_b_gnt", k), b_gnt[k], m[k].gb);
                chk($sformatf("m%0d_done", k), done[k], m[k].ga | m[k].gb);
                chk($sformatf("m%0d_busy", k), busy[k], m[k].act);
                chk($sformatf("m%0d_sel", k), sel[k], m[k].sel);
                chk($sformatf("m%0d_mux", k), mux_o[k], m[k].data);
                chk($sformatf("m%0d_last", k), last[k], m[k].last);
            end
        end
    end

    initial begin
        int ngr, last_g, first_g, fp_a, fp_b;
        Reset_n = 0; A_req = 0; B_req = 0; A_data = 0; B_data = 0;
        tick(3);
        Reset_n = 1;
        // idle after reset
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("s1_sel", sel[0], 0);
            chk("s1_mux", mux_o[0], 0);
            chk("s1_busy", busy[0], 0);
            chk("s1_gnt", {a_gnt[0], b_gnt[0], done[0]}, 0);
            chk("s1_last", last[0], 1);
        end
        // single A request
        A_req = 1; A_data = 2'b10;
        tick(2);
        chk("s2_sel", sel[0], 0);
        chk("s2_mux", mux_o[0], 2'b10);
        chk("s2_busy", busy[0], 1);
        tick(2);
        chk("s2_early_gnt", a_gnt[0], 0);
        tick(1);
        chk("s2_a_gnt", a_gnt[0], 1);
        chk("s2_done", done[0], 1);
        chk("s2_last", last[0], 0);
        A_req = 0; A_data = 0;
        tick(1);
        chk("s2_gnt_end", {a_gnt[0], done[0]}, 0);
        tick(3);
        Reset_n = 0;
        tick(1);
        Reset_n = 1;
        // contention: round-robin vs fixed priority
        A_req = 1; B_req = 1; A_data = 2'b01; B_data = 2'b11;
        ngr = 0; last_g = 0; first_g = -1; fp_a = 0; fp_b = 0;
        for (int i = 0; i <= 22; i++) begin
            tick(1);
            if (a_gnt[0] | b_gnt[0]) begin
                if (ngr > 0) chk("s3_spacing", i - last_g, 6);
                else first_g = i;
                chk("s3_order", b_gnt[0], ngr % 2);
                ngr++;
                last_g = i;
            end
            if (i % 6 == 1) begin
                chk("s3_sel", sel[0], (i / 6) % 2);
                chk("s3_mux", mux_o[0], ((i / 6) % 2) ? 2'b11 : 2'b01);
            end
            if (a_gnt[1]) fp_a++;
            if (b_gnt[1]) fp_b++;
        end
        A_req = 0; B_req = 0;
        chk("s3_first_grant", first_g, 4);
        chk("s3_grants", ngr, 4);
        chk("s4_a_grants", fp_a, 4);
        chk("s4_b_grants", fp_b, 0);
        tick(3);
        Reset_n = 0;
        tick(1);
        Reset_n = 1;
        tick(1);
        // reset during SETTLE
        B_req = 1; B_data = 2'b00;
        tick(3);
        chk("s5_sel_pre", sel[0], 1);
        chk("s5_busy_pre", busy[0], 1);
        Reset_n = 0; B_req = 0;
        tick(1);
        chk("s5_sel", sel[0], 0);
        chk("s5_busy", busy[0], 0);
        Reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("s5_no_gnt", {b_gnt[0], done[0]}, 0);
        end
        // request dropped and data changed during SETTLE
        A_req = 1; A_data = 2'b11;
        tick(2);
        chk("s6_mux_latch", mux_o[0], 2'b11);
        A_req = 0; A_data = 2'b00;
        tick(1);
        chk("s6_mux_e2", mux_o[0], 2'b11);
        tick(1);
        chk("s6_mux_e3", mux_o[0], 2'b11);
        chk("s6_early_gnt", a_gnt[0], 0);
        tick(1);
        chk("s6_a_gnt", a_gnt[0], 1);
        tick(1);
        chk("s6_gnt_end", a_gnt[0], 0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("s6_idle", busy[0], 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
